// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame length and keyboard command bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-flop pin synchroniser with registered falling-edge detect
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1 so an idle (pulled-up) bus never produces a spurious fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_sys,
    input  logic       reset_sys,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ok_q, ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;

    logic clk_lvl, clk_fall;
    logic dat_lvl, dat_fall_unused;
    logic timing_out;

    ps2_sync_edge u_clk_sync (
        .clk_i   (clk_sys),
        .rst_i   (reset_sys),
        .pin_i   (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk_i   (clk_sys),
        .rst_i   (reset_sys),
        .pin_i   (ps2_dat_in),
        .level_o (dat_lvl),
        .fall_o  (dat_fall_unused)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        ok_d      = ok_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        timing_out = 1'b0;
        if (state_q inside {REQ, SHIFT, ACK, WAIT_IDLE}) begin
            to_cnt_d   = to_cnt_q + TO_W'(1);
            timing_out = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        end

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                ready_d  = 1'b1;
                if (tx_valid && ready_q) begin
                    data_d    = tx_data;
                    par_d     = odd_parity(tx_data);
                    bit_cnt_d = 4'd0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + INH_W'(1);
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    dat_oe_d  = ~data_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // bit_cnt_q counts falls already seen: 1..7 -> D1..D7, 8 -> parity, 9 -> stop
                if (clk_fall) begin
                    if (bit_cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                    if (bit_cnt_q != 4'hF) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ok_d    = ~dat_lvl;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    done_d  = ok_q;
                    error_d = ~ok_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timing_out) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            error_d  = 1'b1;
            state_d  = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            par_q     <= 1'b0;
            bit_cnt_q <= 4'd0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            ok_q      <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ok_q      <= ok_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_ready   = ready_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign busy       = busy_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a device-side bus model
module tb_ps2_host_tx;

    logic       clk_sys = 1'b0;
    logic       reset_sys = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    // Open-drain wired-AND of host and device drivers
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .TIMEOUT_CYCLES (4000)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_sys  (reset_sys),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int inh_cnt = 0;

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (tx_done)    done_cnt <= done_cnt + 1;
        if (tx_error)   err_cnt  <= err_cnt + 1;
        if (ps2_clk_oe) inh_cnt  <= inh_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [7:0] d);
        @(negedge clk_sys);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_valid = 1'b0;
    endtask

    // Device model: clock period 200 cycles, samples each bit while clock is low
    task automatic bfm(input logic ack, input int abort_after, output logic [10:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(ps2_dat_in == 1'b0 && ps2_clk_in == 1'b1) && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        check("bfm_request_seen", (n < 400) ? 32'd1 : 32'd0, 32'd1);
        repeat (10) @(negedge clk_sys);
        bits[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (100) @(negedge clk_sys);
            bits[k] = ps2_dat_in;
            if (k == abort_after) return;
            dev_clk_low = 1'b0;
            repeat (100) @(negedge clk_sys);
        end
        dev_dat_low = ack;
        repeat (50) @(negedge clk_sys);
        dev_clk_low = 1'b1;
        repeat (100) @(negedge clk_sys);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clk_sys);
        dev_dat_low = 1'b0;
    endtask

    logic [10:0] bits_a, bits_b;
    int d0, e0, i0, t0, n;

    initial begin
        repeat (3) @(negedge clk_sys);
        reset_sys = 1'b0;
        @(negedge clk_sys);
        check("rst_ready",  32'(tx_ready),   32'd1);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_done",   32'(tx_done),    32'd0);
        check("rst_error",  32'(tx_error),   32'd0);

        // 1: 0xED with ACK
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        issue(8'hED);
        check("t1_busy",  32'(busy),     32'd1);
        check("t1_ready", 32'(tx_ready), 32'd0);
        bfm(1'b1, 0, bits_a);
        repeat (20) @(negedge clk_sys);
        check("t1_frame",   32'(bits_a),      32'h7DA);
        check("t1_inhibit", inh_cnt - i0,     32'd20);
        check("t1_done",    done_cnt - d0,    32'd1);
        check("t1_error",   err_cnt - e0,     32'd0);
        check("t1_ready_after", 32'(tx_ready), 32'd1);
        check("t1_busy_after",  32'(busy),     32'd0);

        // 2: 0xF4 then 0x00 with tx_valid held high
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk_sys);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_data  = 8'h00;
        check("t2_busy_first", 32'(busy), 32'd1);
        bfm(1'b1, 0, bits_a);
        n = 0;
        while (!tx_done && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check("t2_first_done_seen", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        check("t2_ready_at_done", 32'(tx_ready), 32'd0);
        @(negedge clk_sys);
        check("t2_ready_after_done", 32'(tx_ready), 32'd1);
        @(negedge clk_sys);
        check("t2_second_accepted", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        bfm(1'b1, 0, bits_b);
        repeat (20) @(negedge clk_sys);
        check("t2_frame_f4", 32'(bits_a),   32'h5E8);
        check("t2_frame_00", 32'(bits_b),   32'h600);
        check("t2_done",     done_cnt - d0, 32'd2);
        check("t2_error",    err_cnt - e0,  32'd0);

        // 3: no ACK
        d0 = done_cnt; e0 = err_cnt;
        issue(8'hF4);
        bfm(1'b0, 0, bits_a);
        repeat (20) @(negedge clk_sys);
        check("t3_frame",  32'(bits_a),     32'h5E8);
        check("t3_error",  err_cnt - e0,    32'd1);
        check("t3_done",   done_cnt - d0,   32'd0);
        check("t3_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t3_dat_oe", 32'(ps2_dat_oe), 32'd0);

        // 4: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        issue(8'hED);
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("t4_release_seen", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        t0 = cyc;
        n = 0;
        while (!tx_error && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        check("t4_timeout_latency", cyc - t0, 32'd4000);
        check("t4_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t4_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("t4_ready_at_error", 32'(tx_ready), 32'd0);
        @(negedge clk_sys);
        check("t4_ready_next", 32'(tx_ready), 32'd1);
        check("t4_error_cnt", err_cnt - e0,  32'd1);
        check("t4_done_cnt",  done_cnt - d0, 32'd0);

        // 5: reset mid-transfer, then a full 0xFF transfer
        d0 = done_cnt; e0 = err_cnt;
        issue(8'h00);
        bfm(1'b1, 5, bits_a);
        check("t5_partial_bits", 32'(bits_a[5:0]), 32'd0);
        check("t5_dat_oe_pre",   32'(ps2_dat_oe),  32'd1);
        @(posedge clk_sys);
        #3 reset_sys = 1'b1;
        #1;
        check("t5_clk_oe_async", 32'(ps2_clk_oe), 32'd0);
        check("t5_dat_oe_async", 32'(ps2_dat_oe), 32'd0);
        check("t5_busy_async",   32'(busy),       32'd0);
        dev_clk_low = 1'b0;
        @(negedge clk_sys);
        reset_sys = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("t5_no_done",  done_cnt - d0,  32'd0);
        check("t5_no_error", err_cnt - e0,   32'd0);
        check("t5_ready",    32'(tx_ready),  32'd1);
        issue(8'hFF);
        bfm(1'b1, 0, bits_a);
        repeat (20) @(negedge clk_sys);
        check("t5_frame_ff", 32'(bits_a),   32'h7FE);
        check("t5_done",     done_cnt - d0, 32'd1);
        check("t5_error",    err_cnt - e0,  32'd0);

        // 6: tx_valid pulse while busy is ignored
        d0 = done_cnt; e0 = err_cnt;
        issue(8'h12);
        fork
            bfm(1'b1, 0, bits_a);
            begin
                repeat (600) @(negedge clk_sys);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk_sys);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        join
        repeat (20) @(negedge clk_sys);
        check("t6_frame", 32'(bits_a),   32'h624);
        check("t6_done",  done_cnt - d0, 32'd1);
        check("t6_error", err_cnt - e0,  32'd0);
        repeat (100) @(negedge clk_sys);
        check("t6_idle_after", 32'(busy),     32'd0);
        check("t6_done_final", done_cnt - d0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
